// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with a valid/ready request port and a registered response.
// It supports byte, half and word accesses, sign/zero-extended loads and error reporting.
module dmem_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
    parameter int unsigned MEM_DEPTH    = 1048576,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] address,
    input  logic        read_write,
    input  logic [31:0] data_in,
    input  logic [1:0]  access_size,
    input  logic        load_unsigned,
    output logic        resp_valid,
    output logic [31:0] data_out,
    output logic        error
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, next_state;
    logic [7:0]    mem [MEM_DEPTH];
    logic [CW-1:0] count;
    logic [31:0]   pend_data;
    logic          pend_err;

    logic          accept;
    logic [31:0]   offset;
    logic [32:0]   end_addr;
    logic [2:0]    nbytes;
    logic          illegal, misaligned, out_of_range, req_err;
    logic [AW-1:0] idx;
    logic [31:0]   raw, result;

    always_comb begin
        accept   = req_valid && (state == IDLE);
        offset   = address - BASE_ADDR;
        case (access_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        illegal      = (access_size == 2'd3);
        misaligned   = ((access_size == 2'd1) && address[0]) ||
                       ((access_size == 2'd2) && (address[1:0] != 2'b00));
        // 33-bit sum so an offset that wrapped below BASE_ADDR lands out of range
        end_addr     = {1'b0, offset} + {30'b0, nbytes};
        out_of_range = end_addr > 33'(MEM_DEPTH);
        req_err      = illegal || misaligned || out_of_range;

        idx = offset[AW-1:0];
        raw = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};
        case (access_size)
            2'd0:    result = load_unsigned ? {24'b0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
            2'd1:    result = load_unsigned ? {16'b0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
            default: result = raw;
        endcase
        if (read_write || req_err) begin
            result = '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (read_write || req_err || (READ_LATENCY == 1)) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT:    if (count == CW'(1)) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            pend_data <= '0;
            pend_err  <= 1'b0;
            data_out  <= '0;
            error     <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                count     <= CW'(READ_LATENCY - 1);
                pend_data <= result;
                pend_err  <= req_err;
            end else if (state == WAIT) begin
                count <= count - CW'(1);
            end
            // Load data is captured at accept so later stores cannot alter an in-flight read
            if (next_state == RESP) begin
                if (state == IDLE) begin
                    data_out <= result;
                    error    <= req_err;
                end else begin
                    data_out <= pend_data;
                    error    <= pend_err;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && accept && read_write && !req_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (3'(i) < nbytes) begin
                    mem[idx + AW'(i)] <= data_in[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed scoreboard bench for dmem_ctrl: instance 0 uses default parameters,
// instance 1 uses READ_LATENCY=3 with a small memory for reset and back-to-back tests.
module tb_dmem_ctrl;

    localparam logic [31:0] BASE    = 32'h0100_0000;
    localparam int unsigned DEPTH_A = 1048576;
    localparam int unsigned DEPTH_B = 1024;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_s       [2];
    logic        req_valid_s   [2];
    logic        req_ready_s   [2];
    logic [31:0] address_s     [2];
    logic        read_write_s  [2];
    logic [31:0] data_in_s     [2];
    logic [1:0]  access_size_s [2];
    logic        load_unsigned_s [2];
    logic        resp_valid_s  [2];
    logic [31:0] data_out_s    [2];
    logic        error_s       [2];

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    dmem_ctrl #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH_A), .READ_LATENCY(1)) dut_a (
        .clock(clock), .reset(reset_s[0]), .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]),
        .address(address_s[0]), .read_write(read_write_s[0]), .data_in(data_in_s[0]),
        .access_size(access_size_s[0]), .load_unsigned(load_unsigned_s[0]),
        .resp_valid(resp_valid_s[0]), .data_out(data_out_s[0]), .error(error_s[0])
    );

    dmem_ctrl #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH_B), .READ_LATENCY(3)) dut_b (
        .clock(clock), .reset(reset_s[1]), .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]),
        .address(address_s[1]), .read_write(read_write_s[1]), .data_in(data_in_s[1]),
        .access_size(access_size_s[1]), .load_unsigned(load_unsigned_s[1]),
        .resp_valid(resp_valid_s[1]), .data_out(data_out_s[1]), .error(error_s[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic rw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] size, input logic uns);
        read_write_s[s]    = rw;
        address_s[s]       = addr;
        data_in_s[s]       = data;
        access_size_s[s]   = size;
        load_unsigned_s[s] = uns;
    endtask

    // One request: push expectation on drive, pop and compare when resp_valid appears.
    task automatic issue(input int s, input logic rw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] size, input logic uns,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                         input string tag);
        int   guard;
        int   lat;
        exp_t e;
        @(negedge clock);
        guard = 0;
        while (!req_ready_s[s] && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check({tag, "_ready"}, 32'(req_ready_s[s]), 32'd1);
        drive(s, rw, addr, data, size, uns);
        req_valid_s[s] = 1'b1;
        sb.push_back('{data: exp_data, err: exp_err, lat: exp_lat});
        @(negedge clock);
        req_valid_s[s] = 1'b0;
        lat = 1;
        while (!resp_valid_s[s] && lat < 50) begin
            @(negedge clock);
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_lat"},  32'(lat), 32'(e.lat));
        check({tag, "_data"}, data_out_s[s], e.data);
        check({tag, "_err"},  32'(error_s[s]), 32'(e.err));
    endtask

    initial begin
        int   resp_cnt;
        int   pushes;
        int   last_resp;
        exp_t e;

        for (int i = 0; i < 2; i++) begin
            reset_s[i]     = 1'b1;
            req_valid_s[i] = 1'b0;
            drive(i, 1'b0, '0, '0, 2'd0, 1'b0);
        end
        repeat (3) @(negedge clock);
        reset_s[0] = 1'b0;
        reset_s[1] = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_ready", i), 32'(req_ready_s[i]), 32'd1);
            check($sformatf("rst%0d_rvalid", i), 32'(resp_valid_s[i]), 32'd0);
            check($sformatf("rst%0d_data", i), data_out_s[i], 32'd0);
            check($sformatf("rst%0d_err", i), 32'(error_s[i]), 32'd0);
        end

        // Basic store/load and extension
        issue(0, 1'b1, BASE,       32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,          1'b0, 1, "sw0");
        issue(0, 1'b0, BASE,       32'h0,         2'd2, 1'b0, 32'hDEAD_BEEF,  1'b0, 1, "lw0");
        issue(0, 1'b0, BASE,       32'h0,         2'd0, 1'b0, 32'hFFFF_FFEF,  1'b0, 1, "lb0");
        issue(0, 1'b0, BASE,       32'h0,         2'd0, 1'b1, 32'h0000_00EF,  1'b0, 1, "lbu0");
        issue(0, 1'b0, BASE + 2,   32'h0,         2'd1, 1'b0, 32'hFFFF_DEAD,  1'b0, 1, "lh2");
        issue(0, 1'b0, BASE + 2,   32'h0,         2'd1, 1'b1, 32'h0000_DEAD,  1'b0, 1, "lhu2");
        issue(0, 1'b1, BASE + 1,   32'hFFFF_FF12, 2'd0, 1'b0, 32'h0,          1'b0, 1, "sb1");
        issue(0, 1'b0, BASE,       32'h0,         2'd2, 1'b0, 32'hDEAD_12EF,  1'b0, 1, "lw_after_sb");

        // Errors leave memory unchanged
        issue(0, 1'b0, BASE + 1,   32'h0,         2'd1, 1'b0, 32'h0,          1'b1, 1, "lh_mis");
        issue(0, 1'b1, BASE + 2,   32'h1234_5678, 2'd2, 1'b0, 32'h0,          1'b1, 1, "sw_mis");
        issue(0, 1'b1, BASE,       32'h1234_5678, 2'd3, 1'b0, 32'h0,          1'b1, 1, "sw_sz3");
        issue(0, 1'b0, BASE,       32'h0,         2'd3, 1'b0, 32'h0,          1'b1, 1, "ld_sz3");
        issue(0, 1'b0, BASE,       32'h0,         2'd2, 1'b0, 32'hDEAD_12EF,  1'b0, 1, "lw_unchanged");

        // Range boundaries
        issue(0, 1'b1, BASE + DEPTH_A - 4, 32'h8877_6655, 2'd2, 1'b0, 32'h0,         1'b0, 1, "sw_top");
        issue(0, 1'b0, BASE + DEPTH_A - 4, 32'h0,         2'd2, 1'b0, 32'h8877_6655, 1'b0, 1, "lw_top");
        issue(0, 1'b0, BASE + DEPTH_A - 2, 32'h0,         2'd1, 1'b0, 32'hFFFF_8877, 1'b0, 1, "lh_top");
        issue(0, 1'b0, BASE + DEPTH_A - 2, 32'h0,         2'd2, 1'b0, 32'h0,         1'b1, 1, "lw_over");
        issue(0, 1'b1, BASE + DEPTH_A,     32'hAB,        2'd0, 1'b0, 32'h0,         1'b1, 1, "sb_over");
        issue(0, 1'b0, 32'h00FF_FFFC,      32'h0,         2'd2, 1'b0, 32'h0,         1'b1, 1, "lw_below");
        issue(0, 1'b0, BASE + DEPTH_A - 4, 32'h0,         2'd2, 1'b0, 32'h8877_6655, 1'b0, 1, "lw_top_kept");

        // Latency-3 instance: store takes 1 cycle, load takes 3
        issue(1, 1'b1, BASE + 8, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0,         1'b0, 1, "b_sw");
        issue(1, 1'b0, BASE + 8, 32'h0,         2'd2, 1'b0, 32'hCAFE_F00D, 1'b0, 3, "b_lw");
        issue(1, 1'b0, BASE + 9, 32'h0,         2'd0, 1'b0, 32'hFFFF_FFF0, 1'b0, 3, "b_lb");

        // Reset during WAIT drops the response
        @(negedge clock);
        drive(1, 1'b0, BASE + 8, 32'h0, 2'd2, 1'b0);
        req_valid_s[1] = 1'b1;
        @(negedge clock);
        req_valid_s[1] = 1'b0;
        check("b_wait_ready", 32'(req_ready_s[1]), 32'd0);
        reset_s[1] = 1'b1;
        @(negedge clock);
        reset_s[1] = 1'b0;
        check("b_post_rst_ready", 32'(req_ready_s[1]), 32'd1);
        resp_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (resp_valid_s[1]) resp_cnt++;
            @(negedge clock);
        end
        check("b_dropped_resp", 32'(resp_cnt), 32'd0);

        // Back-to-back loads with req_valid held: one accept per 4 cycles
        drive(1, 1'b0, BASE + 8, 32'h0, 2'd1, 1'b1);
        req_valid_s[1] = 1'b1;
        pushes    = 1;
        resp_cnt  = 0;
        last_resp = -1;
        sb.push_back('{data: 32'h0000_F00D, err: 1'b0, lat: 3});
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (resp_valid_s[1]) begin
                check("b2b_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("b2b_data", data_out_s[1], e.data);
                    check("b2b_err",  32'(error_s[1]), 32'(e.err));
                end
                if (last_resp >= 0) check("b2b_gap", 32'(c - last_resp), 32'd4);
                last_resp = c;
                resp_cnt++;
            end
            if (req_ready_s[1]) begin
                if (pushes < 3) begin
                    sb.push_back('{data: 32'h0000_F00D, err: 1'b0, lat: 3});
                    pushes++;
                end else begin
                    req_valid_s[1] = 1'b0;
                end
            end
        end
        req_valid_s[1] = 1'b0;
        check("b2b_resp_count", 32'(resp_cnt), 32'd3);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
